// File: rtl/add3_feeder.sv
// Operand feeder for add3_top: buffers packed 3-lane act/wgt vectors in a FIFO and
// issues them per frame with diagonal lane skew when ADD3_FEED_SKEW_EN is defined.
module add3_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_act,
  input  logic [23:0]      in_wgt,
  input  logic             in_last,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [7:0]       act_in_0,
  output logic [7:0]       act_in_1,
  output logic [7:0]       act_in_2,
  output logic [7:0]       wgt_in_0,
  output logic [7:0]       wgt_in_1,
  output logic [7:0]       wgt_in_2,
  output logic [2:0]       lane_vld,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int ENT_W  = 1 + 6 * DATA_W;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, FIN} state_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0] head;
  logic             full, empty, push, pop;

  state_t           state_q;
  logic             flush_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] vec_cnt_q;

  logic [2:0][DATA_W-1:0] act_p0, wgt_p0;
  logic                   vld_p0;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == FEED) && !empty;
  assign head     = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {in_last, in_wgt, in_act};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= FEED;
          busy_q    <= 1'b1;
          vec_cnt_q <= '0;
        end
        FEED: if (pop) begin
          vec_cnt_q <= vec_cnt_q + 1'b1;
          if (head[ENT_W-1]) begin
`ifdef ADD3_FEED_SKEW_EN
            state_q <= FLUSH;
            flush_q <= 1'b0;
`else
            state_q <= FIN;
            done_q  <= 1'b1;
`endif
          end
        end
        FLUSH: begin
          if (flush_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
          flush_q <= 1'b1;
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p0: popped vector or a zeroed bubble, common to all lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_p0 <= '0;
      wgt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      act_p0 <= pop ? head[23:0]  : '0;
      wgt_p0 <= pop ? head[47:24] : '0;
      vld_p0 <= pop;
    end
  end

`ifdef ADD3_FEED_SKEW_EN
  logic [DATA_W-1:0] act1_p1, wgt1_p1, act2_p1, wgt2_p1, act2_p2, wgt2_p2;
  logic              vld1_p1, vld2_p1, vld2_p2;

  // Stages p1/p2: lane k lags lane 0 by k cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1_p1 <= '0; wgt1_p1 <= '0; vld1_p1 <= 1'b0;
      act2_p1 <= '0; wgt2_p1 <= '0; vld2_p1 <= 1'b0;
      act2_p2 <= '0; wgt2_p2 <= '0; vld2_p2 <= 1'b0;
    end else begin
      act1_p1 <= act_p0[1]; wgt1_p1 <= wgt_p0[1]; vld1_p1 <= vld_p0;
      act2_p1 <= act_p0[2]; wgt2_p1 <= wgt_p0[2]; vld2_p1 <= vld_p0;
      act2_p2 <= act2_p1;   wgt2_p2 <= wgt2_p1;   vld2_p2 <= vld2_p1;
    end
  end

  assign act_in_1 = act1_p1;
  assign wgt_in_1 = wgt1_p1;
  assign act_in_2 = act2_p2;
  assign wgt_in_2 = wgt2_p2;
  assign lane_vld = {vld2_p2, vld1_p1, vld_p0};
`else
  assign act_in_1 = act_p0[1];
  assign wgt_in_1 = wgt_p0[1];
  assign act_in_2 = act_p0[2];
  assign wgt_in_2 = wgt_p0[2];
  assign lane_vld = {3{vld_p0}};
`endif

  assign act_in_0 = act_p0[0];
  assign wgt_in_0 = wgt_p0[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign vec_cnt  = vec_cnt_q;

endmodule

// File: tb/tb_add3_feeder.sv
// Bench for add3_feeder: scoreboard of per-lane expected operands plus table-driven
// frames and hand-written handshake/bubble/reset sequences.
module tb_add3_feeder;
`ifdef ADD3_FEED_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0, start = 1'b0;
  logic [23:0] in_act = '0, in_wgt = '0;
  logic        busy, done;
  logic [7:0]  act_in_0, act_in_1, act_in_2, wgt_in_0, wgt_in_1, wgt_in_2;
  logic [2:0]  lane_vld;
  logic [15:0] vec_cnt;

  add3_feeder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last), .start(start),
    .busy(busy), .done(done),
    .act_in_0(act_in_0), .act_in_1(act_in_1), .act_in_2(act_in_2),
    .wgt_in_0(wgt_in_0), .wgt_in_1(wgt_in_1), .wgt_in_2(wgt_in_2),
    .lane_vld(lane_vld), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] q0[$], q1[$], q2[$];

  typedef struct {
    logic [23:0]      act;
    logic [23:0]      wgt;
    logic             last;
    logic [2:0][15:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0][15:0] mk_exp(input logic [23:0] a, input logic [23:0] w);
    logic [2:0][15:0] r;
    for (int k = 0; k < 3; k++) r[k] = {a[8*k +: 8], w[8*k +: 8]};
    return r;
  endfunction

  task automatic push_v(input logic [23:0] a, input logic [23:0] w, input logic l,
                        input logic [2:0][15:0] e);
    int n = 0;
    in_act = a; in_wgt = w; in_last = l; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    q0.push_back(e[0]); q1.push_back(e[1]); q2.push_back(e[2]);
  endtask

  task automatic push_m(input logic [23:0] a, input logic [23:0] w, input logic l);
    push_v(a, w, l, mk_exp(a, w));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every valid lane must match the next expected operand; idle lanes read 0.
  always @(negedge clk) begin
    logic [15:0] got, e;
    bit have;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        have = 1'b0; e = '0;
        case (k)
          0: got = {act_in_0, wgt_in_0};
          1: got = {act_in_1, wgt_in_1};
          default: got = {act_in_2, wgt_in_2};
        endcase
        if (lane_vld[k]) begin
          case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (have) chk($sformatf("lane%0d_data", k), {16'd0, got}, {16'd0, e});
          else begin
            checks++; errors++;
            $display("FAIL lane%0d_unexpected got %0h expected no valid operand at %0t", k, got, $time);
          end
        end else begin
          chk($sformatf("lane%0d_bubble_zero", k), {16'd0, got}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h332211, 24'h665544, 1'b0, {16'h3366, 16'h2255, 16'h1144}};
    tbl[1] = '{24'hFF0080, 24'h7F8001, 1'b0, {16'hFF7F, 16'h0080, 16'h8001}};
    tbl[2] = '{24'h000000, 24'hFFFFFF, 1'b0, {16'h00FF, 16'h00FF, 16'h00FF}};
    tbl[3] = '{24'hABCDEF, 24'h123456, 1'b0, {16'hAB12, 16'hCD34, 16'hEF56}};
    tbl[4] = '{24'h0A0B0C, 24'hC0B0A0, 1'b0, {16'h0AC0, 16'h0BB0, 16'h0CA0}};
    tbl[5] = '{24'h5A5A5A, 24'hA5A5A5, 1'b1, {16'h5AA5, 16'h5AA5, 16'h5AA5}};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lane_vld", {29'd0, lane_vld}, 32'd0);
    chk("rst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    mon_en = 1'b1;

    // Single-vector frame timing.
    push_m(24'h030201, 24'h060504, 1'b1);
    pulse_start();
    chk("s1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("s2_vld", {29'd0, lane_vld}, SKEW ? 32'd1 : 32'd7);
    chk("s2_act0", {24'd0, act_in_0}, 32'h01);
    chk("s2_wgt0", {24'd0, wgt_in_0}, 32'h04);
    chk("s2_done", {31'd0, done}, SKEW ? 32'd0 : 32'd1);
    tick();
    chk("s3_vld", {29'd0, lane_vld}, SKEW ? 32'd2 : 32'd0);
    chk("s3_act1", {24'd0, act_in_1}, SKEW ? 32'h02 : 32'h00);
    chk("s3_busy", {31'd0, busy}, {31'd0, SKEW});
    tick();
    chk("s4_vld", {29'd0, lane_vld}, SKEW ? 32'd4 : 32'd0);
    chk("s4_wgt2", {24'd0, wgt_in_2}, SKEW ? 32'h06 : 32'h00);
    chk("s4_done", {31'd0, done}, {31'd0, SKEW});
    tick();
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s1_vec_cnt", {16'd0, vec_cnt}, 32'd1);

    // Fill to DEPTH, then a held 5th push only lands after the first pop.
    for (int i = 0; i < 4; i++) begin
      push_m(24'h100000 + 24'(i * 24'h010101), 24'h200000 + 24'(i), (i == 3));
      chk("fill_ready", {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    in_act = 24'h777777; in_wgt = 24'h888888; in_last = 1'b1; in_valid = 1'b1;
    pulse_start();
    chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    q0.push_back(16'h7788); q1.push_back(16'h7788); q2.push_back(16'h7788);
    wait_done("fill");
    chk("fill_vec_cnt", {16'd0, vec_cnt}, 32'd4);
    tick();
    pulse_start();
    wait_done("fifth");
    chk("fifth_vec_cnt", {16'd0, vec_cnt}, 32'd1);
    tick(); tick();

    // Table-driven frame streamed while feeding.
    pulse_start();
    for (int i = 0; i < 6; i++) push_v(tbl[i].act, tbl[i].wgt, tbl[i].last, tbl[i].exp);
    wait_done("tbl");
    chk("tbl_vec_cnt", {16'd0, vec_cnt}, 32'd6);
    tick(); tick();

    // Bubbles from an empty FIFO, plus start ignored while busy.
    push_m(24'h0C0B0A, 24'h0F0E0D, 1'b0);
    push_m(24'h1C1B1A, 24'h1F1E1D, 1'b0);
    pulse_start();
    tick(); tick();
    chk("bub_cnt2", {16'd0, vec_cnt}, 32'd2);
    tick();
    chk("bub1_vld0", {31'd0, lane_vld[0]}, 32'd0);
    chk("bub1_act0", {24'd0, act_in_0}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bub2_vld0", {31'd0, lane_vld[0]}, 32'd0);
    chk("busy_start_ign", {31'd0, busy}, 32'd1);
    chk("busy_start_cnt", {16'd0, vec_cnt}, 32'd2);
    push_m(24'h2C2B2A, 24'h2F2E2D, 1'b1);
    chk("bub3_vld0", {31'd0, lane_vld[0]}, 32'd0);
    wait_done("bub");
    chk("bub_vec_cnt", {16'd0, vec_cnt}, 32'd3);
    tick(); tick();

    // Reset mid-FEED with two entries still queued.
    push_m(24'h414243, 24'h515253, 1'b0);
    push_m(24'h444546, 24'h545556, 1'b0);
    push_m(24'h474849, 24'h575859, 1'b1);
    pulse_start();
    tick();
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {29'd0, lane_vld}, 32'd0);
    chk("mid_rst_lanes", {act_in_0, act_in_1, act_in_2, 8'd0}, 32'd0);
    chk("mid_rst_wgts", {wgt_in_0, wgt_in_1, wgt_in_2, 8'd0}, 32'd0);
    chk("mid_rst_busy", {30'd0, busy, done}, 32'd0);
    chk("mid_rst_cnt", {16'd0, vec_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    q0.delete(); q1.delete(); q2.delete();
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    mon_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_feed_vld", {29'd0, lane_vld}, 32'd0);
      chk("empty_feed_busy", {31'd0, busy}, 32'd1);
    end
    push_m(24'h616263, 24'h717273, 1'b1);
    wait_done("post_rst");
    chk("post_rst_cnt", {16'd0, vec_cnt}, 32'd1);
    tick(); tick();

    chk("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add3_feeder.md
# add3_feeder

Operand feeder that drives the `act_in_0..2` / `wgt_in_0..2` lanes of `add3_top`. It is the producer side of the interface that `add3_top` consumes. It accepts packed 3-lane activation/weight vectors over a valid/ready handshake and buffers them in a small FIFO. On `start` it issues the buffered vectors to the array with systolic diagonal skew, so lane k lags lane 0 by k cycles. It signals `done` when the last lane of the last vector has been presented.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of `vec_cnt`.

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: load vector valid.
- `in_ready` output 1: FIFO can accept; equals `!full`.
- `in_act` input 24: lane k activation in bits [8k+7:8k].
- `in_wgt` input 24: lane k weight in bits [8k+7:8k].
- `in_last` input 1: marks the final vector of a frame.
- `start` input 1: single-cycle pulse that begins feeding.
- `busy` output 1: high while a frame is being fed or flushed.
- `done` output 1: single-cycle pulse at frame end.
- `act_in_0`, `act_in_1`, `act_in_2` output 8: activation lanes to the array.
- `wgt_in_0`, `wgt_in_1`, `wgt_in_2` output 8: weight lanes to the array.
- `lane_vld` output 3: bit k high when lane k carries a real operand.
- `vec_cnt` output CNT_W: number of vectors popped in the current frame.

## Operation
- FIFO entry holds {in_last, in_wgt, in_act} (49 bits).
- Push occurs when `in_valid && in_ready`. Loading is permitted in any state.
- When full, `in_ready`=0 even if a pop occurs in the same cycle; there is no pass-through.
- FSM states: IDLE, FEED, FLUSH, FIN.
  - IDLE: on `start` go to FEED and clear `vec_cnt`. `start` in any other state is ignored.
  - FEED: if FIFO is non-empty, pop one entry per cycle and increment `vec_cnt` (wraps at 2^CNT_W). If FIFO is empty, insert a bubble: the lane gets operand 0 and its `lane_vld` bit is 0. A pop with last=1 moves to FLUSH.
  - FLUSH: no pops. A 2-cycle counter drains the skew pipeline, then go to FIN.
  - FIN: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in FEED, FLUSH and FIN.
- Skew: lane 0 has 1 output register stage, lane 1 has 2, lane 2 has 3. Each lane's act, wgt and vld bit travel together.
- Invalid lanes drive 0 on act and wgt.
- Reset mid-operation: all state, the FIFO (pointers cleared, contents discarded), the skew stages and `vec_cnt` clear immediately. FSM returns to IDLE.

## Timing
- Reset values: `in_ready`=1 after `rst_n` deasserts; during reset `in_ready`=0. All lane outputs, `lane_vld`, `busy`, `done` and `vec_cnt` are 0.
- `start` sampled at cycle s: FEED at s+1; first pop may occur at s+1.
- Vector popped at cycle t: lane 0 at t+1, lane 1 at t+2, lane 2 at t+3.
- Last vector popped at t: FLUSH during t+1 and t+2, FIN at t+3. `done` is high at t+3, coincident with lane 2 of the last vector. `busy` falls at t+4.
- Back-to-back frames: `start` at t+4 or later is accepted.
- Throughput: 1 vector/cycle while the FIFO is non-empty.

## Configuration
- `ADD3_FEED_SKEW_EN`
  - Defined: diagonal skew as above, with FLUSH lasting 2 cycles.
  - Undefined: all lanes use 1 register stage, so the vector popped at t appears on all lanes at t+1. FLUSH is bypassed: the last pop at t leads to FIN at t+1, so `done` is high at t+1 and `busy` falls at t+2.

## Test plan
- Reset, then push act=0x030201 and wgt=0x060504 with last=1, then `start` at s. Expect pop at s+1, `act_in_0`=0x01/`wgt_in_0`=0x04 at s+2, lane 1 =0x02/0x05 at s+3, lane 2 =0x03/0x06 and `done` at s+4, and `busy`=0 at s+5.
- Push DEPTH vectors with `in_valid` held high: `in_ready` drops after the 4th push. A 5th push is not accepted until the cycle after the first pop.
- Feed 2 vectors, let the FIFO run empty for 3 cycles, then push a last vector. Expect `lane_vld` bubbles with zero operands, then completion, and `vec_cnt`=3.
- Assert `start` while `busy`=1: no effect, and `vec_cnt` is not cleared.
- Assert `rst_n`=0 in FEED with 2 entries queued: all outputs read 0 immediately. After release, `in_ready`=1 and `start` with an empty FIFO produces only bubbles.
- Build without `ADD3_FEED_SKEW_EN` and repeat the first scenario: all three lanes are valid at s+2, with `done` at s+2.
